// File: rtl/vending_machine_param.sv
// Parameterised coin-operated vending machine: accumulates credit, vends at PRICE,
// refunds on cancel, and returns coins while out of stock. All outputs registered.
module vending_machine_param #(
   parameter int CREDIT_W   = 8,
   parameter int PRICE      = 15,
   parameter int COIN1      = 5,
   parameter int COIN2      = 10,
   parameter int COIN3      = 20,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          in,
   input  logic                cancel,
   input  logic                restock,
   output logic                out,
   output logic [CREDIT_W-1:0] change,
   output logic [CREDIT_W-1:0] credit,
   output logic                sold_out
);

   localparam int MAX_COIN = (COIN1 > COIN2) ? ((COIN1 > COIN3) ? COIN1 : COIN3)
                                             : ((COIN2 > COIN3) ? COIN2 : COIN3);

   if (PRICE - 1 + MAX_COIN >= (1 << CREDIT_W)) begin : g_bad_credit_w
      $error("vending_machine_param: CREDIT_W too narrow for PRICE-1+max coin");
   end
   if (PRICE < 1) begin : g_bad_price
      $error("vending_machine_param: PRICE must be at least 1");
   end
   if (STOCK_INIT < 0 || STOCK_INIT >= (1 << STOCK_W)) begin : g_bad_stock
      $error("vending_machine_param: STOCK_INIT out of range for STOCK_W");
   end

   localparam logic [CREDIT_W-1:0] P_PRICE = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] P_C1    = CREDIT_W'(COIN1);
   localparam logic [CREDIT_W-1:0] P_C2    = CREDIT_W'(COIN2);
   localparam logic [CREDIT_W-1:0] P_C3    = CREDIT_W'(COIN3);
   localparam logic [STOCK_W-1:0]  P_STOCK = STOCK_W'(STOCK_INIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_SOLDOUT
   } state_t;

   state_t                state_q, state_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d;
   logic [CREDIT_W-1:0]   change_q, change_d;
   logic [STOCK_W-1:0]    stock_q, stock_d;
   logic                  out_q, out_d;
   logic                  sold_out_q, sold_out_d;

   logic [CREDIT_W-1:0]   coin;
   logic [CREDIT_W-1:0]   sum;

   always_comb begin
      coin = '0;
      unique case (in)
         2'b01:   coin = P_C1;
         2'b10:   coin = P_C2;
         2'b11:   coin = P_C3;
         default: coin = '0;
      endcase
   end

   // credit stays below PRICE, so the parameter check guarantees sum cannot wrap
   assign sum = credit_q + coin;

   always_comb begin
      out_d    = 1'b0;
      change_d = '0;
      credit_d = credit_q;
      stock_d  = stock_q;

      unique case (state_q)
         S_SOLDOUT: begin
            change_d = sum;
            credit_d = '0;
         end
         default: begin
            if (cancel) begin
               change_d = sum;
               credit_d = '0;
            end else if (sum >= P_PRICE) begin
               out_d    = 1'b1;
               change_d = sum - P_PRICE;
               credit_d = '0;
               stock_d  = stock_q - STOCK_W'(1);
            end else begin
               credit_d = sum;
            end
         end
      endcase

      // reload overrides any decrement from a vend in the same cycle
      if (restock) begin
         stock_d = P_STOCK;
      end

      sold_out_d = (stock_d == '0);

      if (stock_d == '0) begin
         state_d = S_SOLDOUT;
      end else if (credit_d == '0) begin
         state_d = S_IDLE;
      end else begin
         state_d = S_COLLECT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= (P_STOCK == '0) ? S_SOLDOUT : S_IDLE;
         credit_q   <= '0;
         change_q   <= '0;
         stock_q    <= P_STOCK;
         out_q      <= 1'b0;
         sold_out_q <= (P_STOCK == '0);
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         change_q   <= change_d;
         stock_q    <= stock_d;
         out_q      <= out_d;
         sold_out_q <= sold_out_d;
      end
   end

   assign out      = out_q;
   assign change   = change_q;
   assign credit   = credit_q;
   assign sold_out = sold_out_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed and randomised bench for vending_machine_param with default parameters,
// checked against an integer model of the vending rules.
module tb_vending_machine_param;

   localparam int PRICE      = 15;
   localparam int STOCK_INIT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] in_s = 2'b00;
   logic       cancel_s = 1'b0;
   logic       restock_s = 1'b0;
   logic       out_s;
   logic [7:0] change_s;
   logic [7:0] credit_s;
   logic       sold_out_s;

   int n_vec  = 0;
   int n_fail = 0;

   int m_credit = 0;
   int m_stock  = STOCK_INIT;
   int m_out    = 0;
   int m_change = 0;

   vending_machine_param dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in_s),
      .cancel   (cancel_s),
      .restock  (restock_s),
      .out      (out_s),
      .change   (change_s),
      .credit   (credit_s),
      .sold_out (sold_out_s)
   );

   always #5 clk = ~clk;

   function automatic int coin_val(input logic [1:0] c);
      case (c)
         2'b01:   return 5;
         2'b10:   return 10;
         2'b11:   return 20;
         default: return 0;
      endcase
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance the model by one cycle of the vending rules.
   task automatic model_step(input logic r, input logic [1:0] c, input logic can, input logic rs);
      int total;
      if (r) begin
         m_credit = 0;
         m_stock  = STOCK_INIT;
         m_out    = 0;
         m_change = 0;
         return;
      end
      total    = m_credit + coin_val(c);
      m_out    = 0;
      m_change = 0;
      if (m_stock == 0 || can) begin
         m_change = total;
         m_credit = 0;
      end else if (total >= PRICE) begin
         m_out    = 1;
         m_change = total - PRICE;
         m_credit = 0;
         m_stock  = m_stock - 1;
      end else begin
         m_credit = total;
      end
      if (rs) m_stock = STOCK_INIT;
   endtask

   // Drive one cycle, then compare all outputs against the model.
   task automatic step(input logic r, input logic [1:0] c, input logic can, input logic rs);
      @(negedge clk);
      rst       = r;
      in_s      = c;
      cancel_s  = can;
      restock_s = rs;
      @(posedge clk);
      #1;
      model_step(r, c, can, rs);
      check("out",      int'(out_s),      m_out);
      check("change",   int'(change_s),   m_change);
      check("credit",   int'(credit_s),   m_credit);
      check("sold_out", int'(sold_out_s), (m_stock == 0) ? 1 : 0);
   endtask

   initial begin
      step(1'b1, 2'b00, 1'b0, 1'b0);
      step(1'b1, 2'b11, 1'b1, 1'b1);
      check("reset_credit", int'(credit_s), 0);
      check("reset_sold_out", int'(sold_out_s), 0);

      // two-coin exact vend
      step(1'b0, 2'b01, 1'b0, 1'b0);
      check("r28_credit", int'(credit_s), 5);
      step(1'b0, 2'b10, 1'b0, 1'b0);
      check("r28_out", int'(out_s), 1);
      check("r28_change", int'(change_s), 0);
      check("r28_sold_out", int'(sold_out_s), 0);

      // overpay, then last item sells out
      step(1'b1, 2'b00, 1'b0, 1'b0);
      step(1'b0, 2'b11, 1'b0, 1'b0);
      check("r29_out1", int'(out_s), 1);
      check("r29_change1", int'(change_s), 5);
      step(1'b0, 2'b10, 1'b0, 1'b0);
      check("r29_credit", int'(credit_s), 10);
      step(1'b0, 2'b10, 1'b0, 1'b0);
      check("r29_out2", int'(out_s), 1);
      check("r29_change2", int'(change_s), 5);
      check("r29_sold_out", int'(sold_out_s), 1);

      // sold out: coin bounces, restock, then vend
      step(1'b0, 2'b10, 1'b0, 1'b0);
      check("r31_change", int'(change_s), 10);
      check("r31_out", int'(out_s), 0);
      step(1'b0, 2'b00, 1'b0, 1'b1);
      check("r31_restock", int'(sold_out_s), 0);
      step(1'b0, 2'b11, 1'b0, 1'b0);
      check("r31_out2", int'(out_s), 1);
      check("r31_change2", int'(change_s), 5);

      // cancel refunds credit plus same-cycle coin
      step(1'b1, 2'b00, 1'b0, 1'b0);
      step(1'b0, 2'b01, 1'b0, 1'b0);
      step(1'b0, 2'b10, 1'b1, 1'b0);
      check("r30_change", int'(change_s), 15);
      check("r30_out", int'(out_s), 0);
      check("r30_credit", int'(credit_s), 0);

      // reset mid-transaction discards credit; stock back to 2
      step(1'b0, 2'b10, 1'b0, 1'b0);
      check("r32_credit_pre", int'(credit_s), 10);
      step(1'b1, 2'b00, 1'b0, 1'b0);
      check("r32_credit", int'(credit_s), 0);
      check("r32_change", int'(change_s), 0);
      step(1'b0, 2'b11, 1'b0, 1'b0);
      step(1'b0, 2'b11, 1'b0, 1'b0);
      check("r32_stock2", int'(sold_out_s), 1);

      // empty cancel
      step(1'b1, 2'b00, 1'b0, 1'b0);
      step(1'b0, 2'b00, 1'b1, 1'b0);
      check("r33_change", int'(change_s), 0);
      check("r33_out", int'(out_s), 0);

      // vend and restock in the same cycle keeps the reloaded stock
      step(1'b0, 2'b11, 1'b0, 1'b0);
      step(1'b0, 2'b11, 1'b0, 1'b1);
      check("vend_restock_out", int'(out_s), 1);
      check("vend_restock_sold", int'(sold_out_s), 0);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 14) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/vending_machine_param.md
VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 SHALL provide parameter CREDIT_W, default 8: width of credit, change and price arithmetic in currency units.
REQ-002 SHALL provide parameter PRICE, default 15: product price in units, range 1..2^CREDIT_W-1.
REQ-003 SHALL provide parameters COIN1, COIN2, COIN3, defaults 5, 10, 20: coin values for codes 01, 10, 11.
REQ-004 SHALL provide parameter STOCK_W, default 4: width of the stock counter.
REQ-005 SHALL provide parameter STOCK_INIT, default 2: stock loaded at reset and on restock, range 0..2^STOCK_W-1.
REQ-006 SHALL have clk  input  1  the only clock; all state changes on its rising edge.
REQ-007 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have in  input  2  coin code sampled every cycle: 00 none, 01 COIN1, 10 COIN2, 11 COIN3.
REQ-009 SHALL have cancel  input  1  refund request, sampled every cycle.
REQ-010 SHALL have restock  input  1  reload stock to STOCK_INIT, sampled every cycle.
REQ-011 SHALL have out  output  1  registered one-cycle product-dispense pulse.
REQ-012 SHALL have change  output  CREDIT_W  registered change amount in units, valid for one cycle, 0 otherwise.
REQ-013 SHALL have credit  output  CREDIT_W  registered current accumulated credit.
REQ-014 SHALL have sold_out  output  1  registered, high while stock equals 0.

Function
REQ-015 SHALL compute sum = credit + coin value of in, without overflow; PRICE-1+max(COIN1,COIN2,COIN3) SHALL be less than 2^CREDIT_W (elaboration-time check).
REQ-016 SHALL register all outputs; the response to inputs sampled on edge N appears after edge N and holds exactly one cycle for out and change.
REQ-017 SHALL operate as a three-state machine: IDLE (credit 0, stock>0), COLLECT (0<credit<PRICE), SOLDOUT (stock 0).
REQ-018 SHALL, in IDLE or COLLECT with cancel=0 and sum<PRICE, set credit=sum, out=0, change=0.
REQ-019 SHALL, in IDLE or COLLECT with cancel=0 and sum>=PRICE, set out=1, change=sum-PRICE, credit=0, stock decremented by 1.
REQ-020 SHALL, on cancel=1, refund change=sum (credit plus any coin of the same cycle), credit=0, out=0; cancel has priority over vending.
REQ-021 SHALL, on cancel=1 with sum=0, produce change=0 and no other effect.
REQ-022 SHALL, in SOLDOUT, return each inserted coin as change equal to its value on the next cycle, keep credit=0, out=0.
REQ-023 SHALL never decrement stock below 0; the vend that takes stock from 1 to 0 sets sold_out=1 in the same cycle as out=1.
REQ-024 SHALL, on restock=1, set stock=STOCK_INIT, with sold_out=(STOCK_INIT==0); a vend or refund in the same cycle completes normally and does not decrement the reloaded stock.
REQ-025 SHALL, on restock=1 in SOLDOUT with a coin present, treat the coin under SOLDOUT rules (refund); credit accumulates from the following cycle.

Reset
REQ-026 SHALL, while rst=1, set credit=0, out=0, change=0, stock=STOCK_INIT, sold_out=(STOCK_INIT==0), ignoring in, cancel and restock.
REQ-027 SHALL discard accumulated credit on reset mid-transaction without emitting change.

Verification (PRICE=15, coins 5/10/20, STOCK_INIT=2)
REQ-028 SHALL verify: in=01 then 10 on consecutive cycles -> credit=5, then out=1, change=0, credit=0, sold_out=0.
REQ-029 SHALL verify: in=11 from IDLE -> out=1, change=5; then in=10,10 -> credit=10, then out=1, change=5, sold_out=1.
REQ-030 SHALL verify: in=01 then cancel=1 with in=10 -> out=0, change=15, credit=0.
REQ-031 SHALL verify: in SOLDOUT, in=10 -> change=10, out=0; then restock=1 -> sold_out=0; then in=11 -> out=1, change=5.
REQ-032 SHALL verify: credit=10 then rst=1 for one cycle -> credit=0, change=0, out=0, stock=2.
REQ-033 SHALL verify: cancel=1 with credit=0 and in=00 -> change=0, out=0, state unchanged.
